// File: rtl/beat_pkg.sv
// Shared types and constants for the PPG beat detector.
package beat_pkg;

    typedef enum logic [1:0] {S_INIT, S_RISE, S_FALL} beat_state_t;

    localparam int unsigned AVG_DEPTH = 4;
    localparam int unsigned AVG_SHIFT = 2;

endpackage

// File: rtl/interval_avg.sv
// Mean of the last AVG_DEPTH peak-to-peak intervals, kept as a running sum over a history
// shift register. Only instantiated when BEAT_AVG_EN is defined.
module interval_avg
    import beat_pkg::*;
#(
    parameter int unsigned GAP_W = 12
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [GAP_W-1:0] in_interval,
    output logic [GAP_W-1:0] avg_interval,
    output logic             avg_valid
);

    localparam int unsigned SUM_W = GAP_W + AVG_SHIFT;
    localparam int unsigned CNT_W = $clog2(AVG_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(AVG_DEPTH);

    logic [GAP_W-1:0] hist_q [AVG_DEPTH];
    logic [SUM_W-1:0] sum_q;
    logic [CNT_W-1:0] seen_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(AVG_DEPTH); i++) hist_q[i] <= '0;
            sum_q  <= '0;
            seen_q <= '0;
        end else if (clear) begin
            for (int i = 0; i < int'(AVG_DEPTH); i++) hist_q[i] <= '0;
            sum_q  <= '0;
            seen_q <= '0;
        end else if (in_valid) begin
            hist_q[0] <= in_interval;
            for (int i = 1; i < int'(AVG_DEPTH); i++) hist_q[i] <= hist_q[i-1];
            // Oldest entry leaves the window as the new one enters.
            sum_q <= sum_q + SUM_W'(in_interval) - SUM_W'(hist_q[AVG_DEPTH-1]);
            if (seen_q != FULL) seen_q <= seen_q + 1'b1;
        end
    end

    assign avg_interval = GAP_W'(sum_q >> AVG_SHIFT);
    assign avg_valid    = (seen_q == FULL);

endmodule

// File: rtl/beat_detector.sv
// Hysteresis peak/trough detector with refractory gap and peak-to-peak interval measurement.
// Optional interval averaging is enabled by defining BEAT_AVG_EN.
module beat_detector
    import beat_pkg::*;
#(
    parameter int unsigned W       = 10,
    parameter int unsigned HYST    = 8,
    parameter int unsigned MIN_GAP = 40,
    parameter int unsigned GAP_W   = 12,
    parameter int unsigned COUNT_W = 10
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               sample_valid,
    input  logic [W-1:0]       sample,
    output logic               peak_pulse,
    output logic               trough_pulse,
    output logic [COUNT_W-1:0] num_peaks,
    output logic [COUNT_W-1:0] num_troughs,
    output logic [GAP_W-1:0]   interval,
    output logic               interval_valid,
    output logic [GAP_W-1:0]   avg_interval,
    output logic               avg_valid
);

    localparam logic [W:0]     HYST_V    = (W+1)'(HYST);
    localparam logic [GAP_W:0] MIN_GAP_V = (GAP_W+1)'(MIN_GAP);

    beat_state_t        state_q, state_d;
    logic [W-1:0]       max_q, max_d, min_q, min_d;
    logic [GAP_W-1:0]   gap_q, gap_d, gap_sat;
    logic [GAP_W:0]     gap_inc;
    logic               first_q, first_d;
    logic [COUNT_W-1:0] npk_q, npk_d, ntr_q, ntr_d;
    logic [GAP_W-1:0]   interval_q, interval_d;
    logic               peak_q, peak_d, trough_q, trough_d, ival_q, ival_d;
    logic [W:0]         fall_diff, rise_diff;

    // Widened by one bit so gap+1 at saturation still clears the refractory test.
    assign gap_inc   = {1'b0, gap_q} + 1'b1;
    assign gap_sat   = (&gap_q) ? gap_q : gap_q + 1'b1;
    assign fall_diff = {1'b0, max_q} - {1'b0, sample};
    assign rise_diff = {1'b0, sample} - {1'b0, min_q};

    always_comb begin
        state_d    = state_q;
        max_d      = max_q;
        min_d      = min_q;
        gap_d      = gap_q;
        first_d    = first_q;
        npk_d      = npk_q;
        ntr_d      = ntr_q;
        interval_d = interval_q;
        peak_d     = 1'b0;
        trough_d   = 1'b0;
        ival_d     = 1'b0;
        if (sample_valid) begin
            gap_d = gap_sat;
            case (state_q)
                S_INIT: begin
                    max_d   = sample;
                    min_d   = sample;
                    state_d = S_RISE;
                end
                S_RISE: begin
                    if (sample > max_q) begin
                        max_d = sample;
                    end else if (fall_diff >= HYST_V) begin
                        min_d   = sample;
                        state_d = S_FALL;
                        // A peak inside the refractory window still moves the FSM.
                        if (first_q || gap_inc >= MIN_GAP_V) begin
                            peak_d = 1'b1;
                            npk_d  = (&npk_q) ? npk_q : npk_q + 1'b1;
                            if (!first_q) begin
                                interval_d = gap_sat;
                                ival_d     = 1'b1;
                            end
                            first_d = 1'b0;
                            gap_d   = '0;
                        end
                    end
                end
                S_FALL: begin
                    if (sample < min_q) begin
                        min_d = sample;
                    end else if (rise_diff >= HYST_V) begin
                        trough_d = 1'b1;
                        ntr_d    = (&ntr_q) ? ntr_q : ntr_q + 1'b1;
                        max_d    = sample;
                        state_d  = S_RISE;
                    end
                end
                default: state_d = S_INIT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_INIT;
            max_q      <= '0;
            min_q      <= '0;
            gap_q      <= '0;
            first_q    <= 1'b1;
            npk_q      <= '0;
            ntr_q      <= '0;
            interval_q <= '0;
            peak_q     <= 1'b0;
            trough_q   <= 1'b0;
            ival_q     <= 1'b0;
        end else if (clear) begin
            state_q    <= S_INIT;
            max_q      <= '0;
            min_q      <= '0;
            gap_q      <= '0;
            first_q    <= 1'b1;
            npk_q      <= '0;
            ntr_q      <= '0;
            interval_q <= '0;
            peak_q     <= 1'b0;
            trough_q   <= 1'b0;
            ival_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            max_q      <= max_d;
            min_q      <= min_d;
            gap_q      <= gap_d;
            first_q    <= first_d;
            npk_q      <= npk_d;
            ntr_q      <= ntr_d;
            interval_q <= interval_d;
            peak_q     <= peak_d;
            trough_q   <= trough_d;
            ival_q     <= ival_d;
        end
    end

    assign peak_pulse     = peak_q;
    assign trough_pulse   = trough_q;
    assign num_peaks      = npk_q;
    assign num_troughs    = ntr_q;
    assign interval       = interval_q;
    assign interval_valid = ival_q;

`ifdef BEAT_AVG_EN
    interval_avg #(
        .GAP_W(GAP_W)
    ) u_interval_avg (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear       (clear),
        .in_valid    (ival_q),
        .in_interval (interval_q),
        .avg_interval(avg_interval),
        .avg_valid   (avg_valid)
    );
`else
    assign avg_interval = '0;
    assign avg_valid    = 1'b0;
`endif

endmodule
